// File: rtl/stopwatch_calc_display_ctrl.sv
// Mode/display controller: key edge decode, stopwatch/calculator mode FSM
// and one shared sequential double-dabble converter for three digit buses.
module stopwatch_calc_display_ctrl #(
    parameter int NDIG  = 4,
    parameter int OPDIG = 2,
    parameter int VAL_W = 32,
    parameter int LZB   = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         key_code,
    input  logic               key_valid,
    input  logic [VAL_W-1:0]   sw_count,
    input  logic [VAL_W-1:0]   calc_result,
    input  logic               calc_neg,
    input  logic               calc_valid,
    input  logic [VAL_W-1:0]   op_a,
    input  logic [VAL_W-1:0]   op_b,
    output logic               mode,
    output logic [1:0]         sw_cmd,
    output logic [4*NDIG-1:0]  main_digits,
    output logic [4*OPDIG-1:0] opa_digits,
    output logic [4*OPDIG-1:0] opb_digits
);

    typedef enum logic {M_SW, M_CALC} mode_e;
    typedef enum logic [1:0] {SW_RUN = 2'd0, SW_HOLD = 2'd1, SW_CLR = 2'd2} cmd_e;
    typedef enum logic [1:0] {CV_IDLE, CV_LOAD, CV_SHIFT, CV_COMMIT} cv_e;
    typedef enum logic [1:0] {SL_MAIN, SL_A, SL_B} slot_e;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int k = 0; k < n; k++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] P10_N   = pow10(NDIG);
    localparam logic [63:0] P10_NM1 = pow10(NDIG - 1);
    localparam logic [63:0] P10_OP  = pow10(OPDIG);
    localparam logic [3:0]  D_DASH  = 4'd10;
    localparam logic [3:0]  D_BLANK = 4'd11;
    localparam logic [4*NDIG-1:0]  BLANK_M = {NDIG{D_BLANK}};
    localparam logic [4*NDIG-1:0]  DASH_M  = {NDIG{D_DASH}};
    localparam logic [4*OPDIG-1:0] BLANK_O = {OPDIG{D_BLANK}};
    localparam int CNT_W = $clog2(VAL_W);
    localparam int MSD_W = $clog2(NDIG);

    logic             kv_q, kv_qq;
    logic [3:0]       kc_q;
    logic             ev;
    mode_e            mode_q, mode_d;
    cmd_e             cmd_q, cmd_d;
    logic             lap_q, lap_d;
    logic [VAL_W-1:0] snap_q, snap_d;
    logic             mode_sw;

    cv_e              cv_q, cv_d;
    slot_e            slot_q;
    logic [VAL_W-1:0] bin_q;
    logic [4*NDIG-1:0] bcd_q, bcd_nx, adj;
    logic [CNT_W-1:0] cnt_q;
    logic             c_neg, c_blank, c_ovf;
    logic [VAL_W-1:0] main_val, ld_val;
    logic [63:0]      ld_thr;
    logic             ld_neg, ld_blank;
    logic [4*NDIG-1:0] fmt;
    logic [MSD_W-1:0] msd;
    logic             nz;
    logic [4*NDIG-1:0]  main_q;
    logic [4*OPDIG-1:0] opa_q, opb_q;

    // Key edge detect on the registered level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kv_q  <= 1'b0;
            kv_qq <= 1'b0;
            kc_q  <= 4'd0;
        end else begin
            kv_q  <= key_valid;
            kv_qq <= kv_q;
            kc_q  <= key_code;
        end
    end

    assign ev = kv_q & ~kv_qq;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= M_SW;
            cmd_q  <= SW_CLR;
            lap_q  <= 1'b0;
            snap_q <= '0;
        end else begin
            mode_q <= mode_d;
            cmd_q  <= cmd_d;
            lap_q  <= lap_d;
            snap_q <= snap_d;
        end
    end

    always_comb begin
        mode_d = mode_q;
        cmd_d  = cmd_q;
        lap_d  = lap_q;
        snap_d = snap_q;
        if (ev) begin
            if (mode_q == M_SW) begin
                unique case (1'b1)
                    (kc_q == 4'd14) || (kc_q == 4'd15): mode_d = M_CALC;
                    kc_q == 4'd13: begin
                        cmd_d = SW_RUN;
                        lap_d = 1'b0;
                    end
                    kc_q == 4'd12: cmd_d = SW_HOLD;
                    kc_q == 4'd11: begin
                        lap_d  = 1'b1;
                        snap_d = sw_count;
                    end
                    kc_q == 4'd10: begin
                        cmd_d  = SW_CLR;
                        lap_d  = 1'b0;
                        snap_d = '0;
                    end
                    default: ;
                endcase
            end else if (kc_q == 4'd13) begin
                mode_d = M_SW;
            end
        end
    end

    assign mode_sw  = (mode_d != mode_q);
    assign main_val = (mode_q == M_CALC) ? calc_result :
                      (lap_q ? snap_q : sw_count);

    always_comb begin
        cv_d = cv_q;
        unique case (cv_q)
            CV_IDLE:   cv_d = CV_LOAD;
            CV_LOAD:   cv_d = CV_SHIFT;
            CV_SHIFT:  if (cnt_q == CNT_W'(VAL_W - 1)) cv_d = CV_COMMIT;
            CV_COMMIT: cv_d = CV_LOAD;
            default:   cv_d = CV_IDLE;
        endcase
        if (mode_sw) cv_d = CV_LOAD;
    end

    always_comb begin
        ld_val   = main_val;
        ld_thr   = P10_N;
        ld_neg   = 1'b0;
        ld_blank = 1'b0;
        unique case (slot_q)
            SL_MAIN: begin
                if (mode_q == M_CALC) begin
                    ld_blank = ~calc_valid;
                    ld_neg   = calc_neg;
                    if (calc_neg) ld_thr = P10_NM1;
                end
            end
            SL_A: begin
                ld_val   = op_a;
                ld_thr   = P10_OP;
                ld_blank = (mode_q == M_SW);
            end
            SL_B: begin
                ld_val   = op_b;
                ld_thr   = P10_OP;
                ld_blank = (mode_q == M_SW);
            end
            default: ;
        endcase
    end

    // Add-3 on every digit >= 5, then shift in the next binary bit
    always_comb begin
        adj = bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i+:4] >= 4'd5) adj[4*i+:4] = bcd_q[4*i+:4] + 4'd3;
        end
        bcd_nx = {adj[4*NDIG-2:0], bin_q[VAL_W-1]};
    end

    always_comb begin
        fmt = bcd_q;
        msd = '0;
        nz  = |bcd_q;
        for (int i = 0; i < NDIG; i++) begin
            if (bcd_q[4*i+:4] != 4'd0) msd = MSD_W'(i);
        end
        for (int i = 0; i < NDIG; i++) begin
            if (LZB != 0 && i > int'(msd)) fmt[4*i+:4] = D_BLANK;
            if (c_neg && nz) begin
                if (LZB != 0 ? (i == int'(msd) + 1) : (i == NDIG - 1))
                    fmt[4*i+:4] = D_DASH;
            end
        end
        if (c_blank) fmt = BLANK_M;
        else if (c_ovf) fmt = DASH_M;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cv_q <= CV_IDLE;
        end else begin
            cv_q <= cv_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q  <= SL_MAIN;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            c_neg   <= 1'b0;
            c_blank <= 1'b0;
            c_ovf   <= 1'b0;
            main_q  <= BLANK_M;
            opa_q   <= BLANK_O;
            opb_q   <= BLANK_O;
        end else if (mode_sw) begin
            slot_q <= SL_MAIN;
            main_q <= BLANK_M;
            opa_q  <= BLANK_O;
            opb_q  <= BLANK_O;
        end else begin
            unique case (cv_q)
                CV_LOAD: begin
                    bin_q   <= ld_val;
                    bcd_q   <= '0;
                    cnt_q   <= '0;
                    c_neg   <= ld_neg;
                    c_blank <= ld_blank;
                    c_ovf   <= (64'(ld_val) >= ld_thr);
                end
                CV_SHIFT: begin
                    bin_q <= bin_q << 1;
                    bcd_q <= bcd_nx;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                CV_COMMIT: begin
                    unique case (slot_q)
                        SL_MAIN: begin
                            main_q <= fmt;
                            slot_q <= SL_A;
                        end
                        SL_A: begin
                            opa_q  <= fmt[4*OPDIG-1:0];
                            slot_q <= SL_B;
                        end
                        default: begin
                            opb_q  <= fmt[4*OPDIG-1:0];
                            slot_q <= SL_MAIN;
                        end
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign mode        = mode_q;
    assign sw_cmd      = cmd_q;
    assign main_digits = main_q;
    assign opa_digits  = opa_q;
    assign opb_digits  = opb_q;

endmodule

// File: tb/tb_stopwatch_calc_display_ctrl.sv
// Directed bench for stopwatch_calc_display_ctrl (NDIG=4, OPDIG=2,
// VAL_W=32, LZB=1); digit buses compared as hex nibbles.
module tb_stopwatch_calc_display_ctrl;

    localparam int NDIG  = 4;
    localparam int OPDIG = 2;
    localparam int VAL_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [3:0]        key_code;
    logic              key_valid;
    logic [VAL_W-1:0]  sw_count;
    logic [VAL_W-1:0]  calc_result;
    logic              calc_neg;
    logic              calc_valid;
    logic [VAL_W-1:0]  op_a;
    logic [VAL_W-1:0]  op_b;
    logic              mode;
    logic [1:0]        sw_cmd;
    logic [4*NDIG-1:0]  main_digits;
    logic [4*OPDIG-1:0] opa_digits;
    logic [4*OPDIG-1:0] opb_digits;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stopwatch_calc_display_ctrl #(
        .NDIG(NDIG), .OPDIG(OPDIG), .VAL_W(VAL_W), .LZB(1)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .key_code(key_code), .key_valid(key_valid),
        .sw_count(sw_count),
        .calc_result(calc_result), .calc_neg(calc_neg),
        .calc_valid(calc_valid),
        .op_a(op_a), .op_b(op_b),
        .mode(mode), .sw_cmd(sw_cmd),
        .main_digits(main_digits),
        .opa_digits(opa_digits), .opb_digits(opb_digits)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input int sel);
        if (sel == 0) return 32'(main_digits);
        if (sel == 1) return 32'(opa_digits);
        return 32'(opb_digits);
    endfunction

    task automatic wait_out(input string tag, input int sel,
                            input logic [31:0] exp, input int budget);
        for (int n = 0; n < budget && pick(sel) !== exp; n++)
            @(negedge clk);
        check(tag, pick(sel), exp);
    endtask

    task automatic send_key(input logic [3:0] code, input int hold);
        @(negedge clk);
        key_code  = code;
        key_valid = 1'b1;
        repeat (hold) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int lat;
        rst_n       = 1'b0;
        key_code    = 4'd0;
        key_valid   = 1'b0;
        sw_count    = '0;
        calc_result = '0;
        calc_neg    = 1'b0;
        calc_valid  = 1'b0;
        op_a        = '0;
        op_b        = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mode", 32'(mode), 32'd0);
        check("rst_cmd", 32'(sw_cmd), 32'd2);
        check("rst_main", 32'(main_digits), 32'hBBBB);
        check("rst_opa", 32'(opa_digits), 32'hBB);
        check("rst_opb", 32'(opb_digits), 32'hBB);
        rst_n = 1'b1;
        repeat (30) @(negedge clk);
        check("rst_hold", 32'(main_digits), 32'hBBBB);

        // Held run key -> one event
        sw_count = 32'd1234;
        send_key(4'd13, 50);
        check("run_cmd", 32'(sw_cmd), 32'd0);
        check("run_mode", 32'(mode), 32'd0);
        wait_out("sw_1234", 0, 32'h1234, 136);

        // Lap held while the count moves: only the first cycle snapshots
        sw_count = 32'd57;
        @(negedge clk);
        key_code  = 4'd11;
        key_valid = 1'b1;
        repeat (5) @(negedge clk);
        sw_count = 32'd58;
        repeat (15) @(negedge clk);
        key_valid = 1'b0;
        repeat (3) @(negedge clk);
        sw_count = 32'd90;
        repeat (140) @(negedge clk);
        check("lap_57", 32'(main_digits), 32'hBB57);
        check("lap_cmd", 32'(sw_cmd), 32'd0);
        send_key(4'd13, 4);
        wait_out("live_90", 0, 32'hBB90, 136);
        send_key(4'd12, 4);
        check("hold_cmd", 32'(sw_cmd), 32'd1);
        send_key(4'd10, 4);
        check("clr_cmd", 32'(sw_cmd), 32'd2);
        sw_count = 32'd0;
        wait_out("clr_0", 0, 32'hBBB0, 136);

        // Enter calculator; outputs forced blank the cycle after
        @(negedge clk);
        key_code  = 4'd14;
        key_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("calc_mode", 32'(mode), 32'd1);
        check("chg_blank", 32'(main_digits), 32'hBBBB);
        key_valid = 1'b0;
        repeat (140) @(negedge clk);
        check("nores_blank", 32'(main_digits), 32'hBBBB);
        check("calc_cmd", 32'(sw_cmd), 32'd2);
        calc_valid  = 1'b1;
        calc_result = 32'd7;
        calc_neg    = 1'b1;
        wait_out("neg_7", 0, 32'hBBA7, 136);
        calc_result = 32'd1000;
        wait_out("neg_ovf", 0, 32'hAAAA, 136);
        calc_result = 32'd9999;
        calc_neg    = 1'b0;
        wait_out("pos_9999", 0, 32'h9999, 136);
        calc_result = 32'd0;
        calc_neg    = 1'b1;
        wait_out("neg_zero", 0, 32'hBBB0, 136);

        // Operands
        op_a = 32'd42;
        op_b = 32'd100;
        wait_out("opa_42", 1, 32'h42, 136);
        wait_out("opb_ovf", 2, 32'hAA, 136);
        send_key(4'd13, 4);
        check("sw_mode", 32'(mode), 32'd0);
        check("sw_cmd_keep", 32'(sw_cmd), 32'd2);
        check("opa_force", 32'(opa_digits), 32'hBB);
        repeat (140) @(negedge clk);
        check("opa_sw", 32'(opa_digits), 32'hBB);
        check("opb_sw", 32'(opb_digits), 32'hBB);

        // Asynchronous reset mid-conversion and restart latency
        sw_count = 32'd1234;
        send_key(4'd13, 4);
        check("run_cmd2", 32'(sw_cmd), 32'd0);
        wait_out("sw_1234b", 0, 32'h1234, 136);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_main", 32'(main_digits), 32'hBBBB);
        check("arst_cmd", 32'(sw_cmd), 32'd2);
        @(negedge clk);
        rst_n = 1'b1;
        lat = 0;
        // One idle cycle, then load + 32 shifts + commit
        for (int n = 0; n < 200; n++) begin
            @(posedge clk);
            lat++;
            #1;
            if (main_digits !== 16'hBBBB) break;
        end
        check("restart_lat", 32'(lat), 32'd35);
        check("restart_val", 32'(main_digits), 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
